// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states and response owner.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational winner pick: data first, fetch forced when the starvation guard trips.
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic can_grant,
  input  logic starve_hit,
  output logic if_pick,
  output logic d_pick
);

  assign if_pick = can_grant & if_req & (~d_req | starve_hit);
  assign d_pick  = can_grant & d_req & ~(if_req & starve_hit);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-ported unified memory shared by fetch (read-only) and data (read/write);
// one access in flight, fixed latency, response routed to the registered owner.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  starve_q, starve_d;

  logic resp, can_grant, starve_hit, if_pick, d_pick;

  // Reset is folded into the grant/response qualifiers so every output is quiet while held.
  assign resp       = reset & (state_q == ARB_WAIT) & (cnt_q == '0);
  assign can_grant  = reset & ((state_q == ARB_IDLE) | resp);
  assign starve_hit = (starve_q == SC_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .can_grant (can_grant),
    .starve_hit(starve_hit),
    .if_pick   (if_pick),
    .d_pick    (d_pick)
  );

  assign if_gnt    = if_pick;
  assign d_gnt     = d_pick;
  assign mem_en    = if_pick | d_pick;
  assign mem_we    = d_pick & d_we;
  assign mem_addr  = d_pick ? d_addr : (if_pick ? if_addr : '0);
  assign mem_wdata = (d_pick & d_we) ? d_wdata : '0;

  assign if_rvalid = resp & (owner_q == OWN_IF);
  assign d_rvalid  = resp & (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid & ~we_q) ? mem_rdata : '0;
  assign busy      = reset & (state_q == ARB_WAIT);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;

    if (if_pick | d_pick) begin
      state_d = ARB_WAIT;
      owner_d = d_pick ? OWN_D : OWN_IF;
      we_d    = d_pick & d_we;
      cnt_d   = CNT_W'(MEM_LAT - 1);
    end else if (resp) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
      we_d    = 1'b0;
    end else if (state_q == ARB_WAIT) begin
      cnt_d = cnt_q - 1'b1;
    end

    // Count data wins only while fetch is actually waiting.
    if (!if_req || if_pick)
      starve_d = '0;
    else if (d_pick && !starve_hit)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: a MEM_LAT=2 arbiter for the main scenarios plus a MEM_LAT=1 build for throughput.
module tb_unified_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  logic          if1_req, if1_gnt, if1_rvalid, d1_gnt, d1_rvalid;
  logic          mem1_en, mem1_we, busy1;
  logic [AW-1:0] if1_addr, mem1_addr;
  logic [DW-1:0] if1_rdata, d1_rdata, mem1_wdata, mem1_rdata;

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt), .if_rvalid(if1_rvalid), .if_rdata(if1_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_rdata(mem1_rdata), .busy(busy1)
  );

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b1; if_addr = 64'h40;
    for (int c = 0; c < 2; c++) begin
      smp();
      total++; if ({if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid} !== 7'b0 || mem_addr !== '0)
        begin bad++; $display("FAIL reset_quiet cyc=%0d got=%b addr=%0h exp=0", c, {if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid}, mem_addr); end
      nxt();
    end
    reset = 1'b1;
    smp();
    total++; if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b0)
      begin bad++; $display("FAIL first_grant got gnt=%b en=%b addr=%0h we=%b exp 1 1 40 0", if_gnt, mem_en, mem_addr, mem_we); end
    nxt(); if_req = 1'b0;
    smp();
    total++; if (busy !== 1'b1 || if_rvalid !== 1'b0)
      begin bad++; $display("FAIL first_wait got busy=%b rv=%b exp 1 0", busy, if_rvalid); end
    nxt(); mem_rdata = 64'hDEAD;
    smp();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 64'hDEAD || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL first_resp got rv=%b rd=%0h drv=%b exp 1 dead 0", if_rvalid, if_rdata, d_rvalid); end
    nxt(); mem_rdata = '0;
    smp();
    total++; if (busy !== 1'b0 || if_rvalid !== 1'b0)
      begin bad++; $display("FAIL first_idle got busy=%b rv=%b exp 0 0", busy, if_rvalid); end
  endtask

  task automatic test_simultaneous();
    nxt(); if_req = 1'b1; if_addr = 64'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    smp();
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 64'h100)
      begin bad++; $display("FAIL simul_dfirst got dg=%b ig=%b addr=%0h exp 1 0 100", d_gnt, if_gnt, mem_addr); end
    nxt(); d_req = 1'b0;
    smp();
    total++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL simul_wait got ig=%b dg=%b busy=%b exp 0 0 1", if_gnt, d_gnt, busy); end
    nxt(); mem_rdata = 64'h1234;
    smp();
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 64'h1234 || if_gnt !== 1'b1 || mem_addr !== 64'h200 || busy !== 1'b1)
      begin bad++; $display("FAIL simul_regrant got drv=%b drd=%0h ig=%b addr=%0h busy=%b exp 1 1234 1 200 1", d_rvalid, d_rdata, if_gnt, mem_addr, busy); end
    nxt(); if_req = 1'b0; mem_rdata = '0;
    smp();
    total++; if (busy !== 1'b1 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL simul_wait2 got busy=%b irv=%b drv=%b exp 1 0 0", busy, if_rvalid, d_rvalid); end
    nxt(); mem_rdata = 64'h77;
    smp();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 64'h77 || d_rvalid !== 1'b0 || d_rdata !== '0)
      begin bad++; $display("FAIL simul_ifresp got irv=%b ird=%0h drv=%b drd=%0h exp 1 77 0 0", if_rvalid, if_rdata, d_rvalid, d_rdata); end
    nxt(); mem_rdata = '0;
  endtask

  task automatic test_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h55;
    smp();
    total++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'h55 || mem_addr !== 64'h80)
      begin bad++; $display("FAIL wr_issue got dg=%b we=%b wd=%0h addr=%0h exp 1 1 55 80", d_gnt, mem_we, mem_wdata, mem_addr); end
    nxt(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    smp();
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== '0 || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL wr_quiet got en=%b we=%b wd=%0h drv=%b exp 0 0 0 0", mem_en, mem_we, mem_wdata, d_rvalid); end
    nxt(); mem_rdata = 64'hFFFF;
    smp();
    total++; if (d_rvalid !== 1'b1 || d_rdata !== '0 || if_rvalid !== 1'b0)
      begin bad++; $display("FAIL wr_resp got drv=%b drd=%0h irv=%b exp 1 0 0", d_rvalid, d_rdata, if_rvalid); end
    nxt(); mem_rdata = '0;
  endtask

  task automatic test_starvation();
    logic [5:0] exp_d;
    exp_d = 6'b101111;  // bit k: grant k goes to data
    if_req = 1'b1; if_addr = 64'h600; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h700;
    for (int k = 0; k < 6; k++) begin
      smp();
      total++; if (d_gnt !== exp_d[k] || if_gnt !== ~exp_d[k])
        begin bad++; $display("FAIL starve_grant k=%0d got dg=%b ig=%b exp dg=%b ig=%b", k, d_gnt, if_gnt, exp_d[k], ~exp_d[k]); end
      nxt(); nxt();
    end
    if_req = 1'b0; d_req = 1'b0;
    smp();
    total++; if (mem_en !== 1'b0)
      begin bad++; $display("FAIL starve_drop got en=%b exp 0", mem_en); end
    nxt(); nxt();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    smp();
    total++; if (d_gnt !== 1'b1)
      begin bad++; $display("FAIL mid_grant got dg=%b exp 1", d_gnt); end
    nxt(); d_req = 1'b0; reset = 1'b0;
    smp();
    total++; if (d_rvalid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0)
      begin bad++; $display("FAIL mid_inreset got drv=%b busy=%b en=%b exp 0 0 0", d_rvalid, busy, mem_en); end
    nxt(); reset = 1'b1; mem_rdata = 64'hBAD;
    for (int c = 0; c < 2; c++) begin
      smp();
      total++; if (d_rvalid !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL mid_abandon cyc=%0d got drv=%b busy=%b exp 0 0", c, d_rvalid, busy); end
      nxt();
    end
    mem_rdata = '0; if_req = 1'b1; if_addr = 64'h500;
    smp();
    total++; if (if_gnt !== 1'b1 || busy !== 1'b0 || mem_addr !== 64'h500)
      begin bad++; $display("FAIL mid_regrant got ig=%b busy=%b addr=%0h exp 1 0 500", if_gnt, busy, mem_addr); end
    nxt(); if_req = 1'b0;
    nxt(); mem_rdata = 64'hAB;
    smp();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 64'hAB || d_rvalid !== 1'b0)
      begin bad++; $display("FAIL mid_resp got irv=%b ird=%0h drv=%b exp 1 ab 0", if_rvalid, if_rdata, d_rvalid); end
    nxt(); mem_rdata = '0;
  endtask

  task automatic test_lat1();
    if1_req = 1'b1; if1_addr = 64'h10; mem1_rdata = 64'h0;
    smp();
    total++; if (if1_gnt !== 1'b1 || busy1 !== 1'b0 || if1_rvalid !== 1'b0)
      begin bad++; $display("FAIL lat1_first got ig=%b busy=%b rv=%b exp 1 0 0", if1_gnt, busy1, if1_rvalid); end
    for (int k = 1; k < 5; k++) begin
      nxt(); mem1_rdata = 64'(k + 100);
      smp();
      total++; if (if1_gnt !== 1'b1 || if1_rvalid !== 1'b1 || busy1 !== 1'b1 || if1_rdata !== 64'(k + 100))
        begin bad++; $display("FAIL lat1_stream k=%0d got ig=%b rv=%b busy=%b rd=%0h exp 1 1 1 %0h", k, if1_gnt, if1_rvalid, busy1, if1_rdata, k + 100); end
    end
    nxt(); if1_req = 1'b0; mem1_rdata = 64'h99;
    smp();
    total++; if (if1_gnt !== 1'b0 || if1_rvalid !== 1'b1 || busy1 !== 1'b1 || if1_rdata !== 64'h99)
      begin bad++; $display("FAIL lat1_last got ig=%b rv=%b busy=%b rd=%0h exp 0 1 1 99", if1_gnt, if1_rvalid, busy1, if1_rdata); end
    nxt(); mem1_rdata = '0;
    smp();
    total++; if (busy1 !== 1'b0 || if1_rvalid !== 1'b0)
      begin bad++; $display("FAIL lat1_idle got busy=%b rv=%b exp 0 0", busy1, if1_rvalid); end
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if1_req = 1'b0; if1_addr = '0; mem1_rdata = '0;
    #1;
    test_reset();
    test_simultaneous();
    test_write();
    test_starvation();
    test_reset_mid();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage and the memory stage of Pipelined_CPU.
- The fetch port is read-only. The data port supports reads and writes.
- Arbitrates, issues one access at a time, tracks the fixed memory latency and routes the response back to the owning requester.
- Data has priority. A starvation guard guarantees fetch forward progress.

Parameters:
- ADDR_W, 64, address width in bits
- DATA_W, 64, data width in bits
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1 or more
- STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced to win; legal range 1 or more

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse (reads and writes)
- d_rdata  out  DATA_W  data read data (0 for writes)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  an access is in flight

Behaviour:
- States:
  - IDLE: no access outstanding.
  - WAIT: access outstanding; latency counter running.
- Grant:
  - Grant is combinational from registered state and the req inputs.
  - A grant is possible in IDLE, or in WAIT during the cycle the counter expires (the response cycle). This gives back-to-back throughput of one access per MEM_LAT cycles.
- Priority:
  - If both requesters are pending, d wins.
  - Exception: if starve_cnt == STARVE_MAX, if wins.
- Starvation counter (starve_cnt, width $clog2(STARVE_MAX+1)):
  - Increments on each d_gnt while if_req is high, saturating at STARVE_MAX.
  - Clears on if_gnt, or on any cycle with if_req low.
- Issue:
  - In the grant cycle, mem_en=1, and mem_addr, mem_we and mem_wdata come from the winner.
  - mem_we=0 for fetch.
  - When there is no grant, all mem_* outputs are 0.
- Owner tracking:
  - Owner (IF or D) and we are registered at grant.
  - Counter loads MEM_LAT-1 and goes to WAIT.
- Response:
  - When the counter reaches 0 in WAIT, exactly one of if_rvalid/d_rvalid pulses, per the registered owner.
  - The matching rdata equals mem_rdata in that cycle; otherwise rdata is 0.
  - A d write also pulses d_rvalid, with d_rdata=0.
- After the response: go to IDLE, or stay in WAIT with a reloaded counter if a new grant happened in the same cycle.
- busy: 1 in WAIT, independent of any same-cycle regrant.
- Requests not granted keep waiting. The arbiter never drops a held request.
- Reset (reset==0 at a clock edge):
  - State returns to IDLE; starve_cnt, owner and counter are cleared.
  - No grant and no mem_en while reset is low; all outputs 0.
  - Any in-flight access is abandoned: no rvalid is produced for it, even if its latency expires after reset deasserts.
- Behaviour when a requester drops req before its grant is don't-care for ordering, but must not produce a grant in that cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_WAIT}
  - owner enum {OWN_NONE, OWN_IF, OWN_D}
- One sub-module, mem_arb_pick, is natural: purely combinational priority plus starvation-override pick, with inputs if_req, d_req, can_grant and starve_hit.
- The top level holds the FSM, the counters and the response routing.

Test Plan:
- Reset, idle bus: reset=0 for 2 cycles with if_req=1 → all outputs 0. Release reset, if_addr=0x40 → if_gnt and mem_en same cycle, mem_addr=0x40; mem_rdata=0xDEAD at +2 → if_rvalid=1, if_rdata=0xDEAD.
- Simultaneous requests: if_req=d_req=1, d_we=0, d_addr=0x100 → d_gnt first; if_gnt exactly 2 cycles later, in the d_rvalid cycle.
- Write completion: d_we=1, d_addr=0x80, d_wdata=0x55 → mem_we=1, mem_wdata=0x55; d_rvalid after 2 cycles with d_rdata=0; if_rvalid stays 0.
- Starvation: d_req and if_req held high continuously, STARVE_MAX=4 → 4 d grants, then the 5th grant goes to if; starve_cnt then clears and d wins again.
- Reset mid-operation: d read granted, reset=0 for one cycle at grant+1 → no d_rvalid ever issued; the next request after release is granted from IDLE.
- MEM_LAT=1 build: continuous if_req → if_gnt every cycle, if_rvalid every cycle starting one cycle after the first grant; busy=1 throughout.
